// File: rtl/demux_router.sv
// Registered 1-to-3 stream demultiplexer with one-entry holding slot per sink.
// Words carrying a zero-hot or multi-hot select are dropped and counted.
//
// slot state | meaning
// EMPTY      | no word held, slot can take a new word
// FULL       | word held on outK_data, outK_valid high until the sink takes it
module demux_router #(
   parameter int DATA_W = 4,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              sel1,
   input  logic              sel2,
   input  logic              sel3,
   output logic [DATA_W-1:0] out1_data,
   output logic              out1_valid,
   input  logic              out1_ready,
   output logic [DATA_W-1:0] out2_data,
   output logic              out2_valid,
   input  logic              out2_ready,
   output logic [DATA_W-1:0] out3_data,
   output logic              out3_valid,
   input  logic              out3_ready,
   output logic [CNT_W-1:0]  err_cnt,
   output logic              sel_err
);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_state_t;

   slot_state_t       slot_state [3];
   logic [DATA_W-1:0] slot_data  [3];
   logic [2:0]        sel_vec;
   logic [2:0]        slot_ready;
   logic [2:0]        slot_open;
   logic [2:0]        load;
   logic              legal;
   logic              drop;

   assign sel_vec    = {sel3, sel2, sel1};
   assign slot_ready = {out3_ready, out2_ready, out1_ready};
   assign legal      = (sel_vec == 3'b001) || (sel_vec == 3'b010) || (sel_vec == 3'b100);

   always_comb begin
      slot_open = '0;
      for (int k = 0; k < 3; k++) begin
         slot_open[k] = (slot_state[k] == EMPTY) || slot_ready[k];
      end
   end

   // Illegal selects are always consumed so a bad word never stalls the stream.
   assign in_ready = !rst && (!legal || |(sel_vec & slot_open));
   assign load     = {3{in_valid && in_ready && legal}} & sel_vec;
   assign drop     = in_valid && !legal && !rst;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < 3; k++) begin
            slot_state[k] <= EMPTY;
            slot_data[k]  <= '0;
         end
      end else begin
         for (int k = 0; k < 3; k++) begin
            if (load[k]) begin
               slot_state[k] <= FULL;
               slot_data[k]  <= in_data;
            end else if (slot_state[k] == FULL && slot_ready[k]) begin
               slot_state[k] <= EMPTY;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_cnt <= '0;
         sel_err <= 1'b0;
      end else begin
         sel_err <= drop;
         if (drop && (err_cnt != {CNT_W{1'b1}})) begin
            err_cnt <= err_cnt + CNT_W'(1);
         end
      end
   end

   assign out1_data  = slot_data[0];
   assign out2_data  = slot_data[1];
   assign out3_data  = slot_data[2];
   assign out1_valid = (slot_state[0] == FULL);
   assign out2_valid = (slot_state[1] == FULL);
   assign out3_valid = (slot_state[2] == FULL);

endmodule

// File: tb/tb_demux_router.sv
// Directed vector bench for demux_router: table of handshake cycles plus
// hand-written reset-in-flight and counter saturation sequences.
module tb_demux_router;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] sel;
   logic [2:0] rdy;
   logic [3:0] out1_data, out2_data, out3_data;
   logic       out1_valid, out2_valid, out3_valid;
   logic [7:0] err_cnt;
   logic       sel_err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   demux_router #(.DATA_W(4), .CNT_W(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .sel1       (sel[0]),
      .sel2       (sel[1]),
      .sel3       (sel[2]),
      .out1_data  (out1_data),
      .out1_valid (out1_valid),
      .out1_ready (rdy[0]),
      .out2_data  (out2_data),
      .out2_valid (out2_valid),
      .out2_ready (rdy[1]),
      .out3_data  (out3_data),
      .out3_valid (out3_valid),
      .out3_ready (rdy[2]),
      .err_cnt    (err_cnt),
      .sel_err    (sel_err)
   );

   // sel and rdy are {3,2,1}; expected fields describe state one edge later,
   // except ir which is in_ready before the edge.
   typedef struct {
      logic [3:0] d;
      logic       v;
      logic [2:0] sel;
      logic [2:0] rdy;
      logic       ir;
      logic [2:0] ev;
      logic [3:0] e1, e2, e3;
      logic       ese;
      logic [7:0] ecnt;
   } vec_t;

   vec_t vq[$];

   task automatic check(input string name, input int unsigned act, input int unsigned exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_outputs(input string tag, input logic [2:0] ev, input logic [3:0] e1,
                                input logic [3:0] e2, input logic [3:0] e3,
                                input logic ese, input logic [7:0] ecnt);
      check({tag, " valid"}, {out3_valid, out2_valid, out1_valid}, ev);
      check({tag, " out1_data"}, out1_data, e1);
      check({tag, " out2_data"}, out2_data, e2);
      check({tag, " out3_data"}, out3_data, e3);
      check({tag, " sel_err"}, sel_err, ese);
      check({tag, " err_cnt"}, err_cnt, ecnt);
   endtask

   initial begin
      // reset walk, select sweep, backpressure, stalled sinks holding data
      vq.push_back('{4'h1, 1'b1, 3'b001, 3'b111, 1'b1, 3'b001, 4'h1, 4'h0, 4'h0, 1'b0, 8'd0});
      vq.push_back('{4'h2, 1'b1, 3'b010, 3'b111, 1'b1, 3'b010, 4'h1, 4'h2, 4'h0, 1'b0, 8'd0});
      vq.push_back('{4'h4, 1'b1, 3'b100, 3'b111, 1'b1, 3'b100, 4'h1, 4'h2, 4'h4, 1'b0, 8'd0});
      vq.push_back('{4'h0, 1'b0, 3'b000, 3'b111, 1'b1, 3'b000, 4'h1, 4'h2, 4'h4, 1'b0, 8'd0});
      vq.push_back('{4'h8, 1'b1, 3'b000, 3'b111, 1'b1, 3'b000, 4'h1, 4'h2, 4'h4, 1'b1, 8'd1});
      vq.push_back('{4'h9, 1'b1, 3'b001, 3'b111, 1'b1, 3'b001, 4'h9, 4'h2, 4'h4, 1'b0, 8'd1});
      vq.push_back('{4'hA, 1'b1, 3'b010, 3'b111, 1'b1, 3'b010, 4'h9, 4'hA, 4'h4, 1'b0, 8'd1});
      vq.push_back('{4'hB, 1'b1, 3'b011, 3'b111, 1'b1, 3'b000, 4'h9, 4'hA, 4'h4, 1'b1, 8'd2});
      vq.push_back('{4'hC, 1'b1, 3'b100, 3'b111, 1'b1, 3'b100, 4'h9, 4'hA, 4'hC, 1'b0, 8'd2});
      vq.push_back('{4'hD, 1'b1, 3'b101, 3'b111, 1'b1, 3'b000, 4'h9, 4'hA, 4'hC, 1'b1, 8'd3});
      vq.push_back('{4'hE, 1'b1, 3'b110, 3'b111, 1'b1, 3'b000, 4'h9, 4'hA, 4'hC, 1'b1, 8'd4});
      vq.push_back('{4'hF, 1'b1, 3'b111, 3'b111, 1'b1, 3'b000, 4'h9, 4'hA, 4'hC, 1'b1, 8'd5});
      vq.push_back('{4'h3, 1'b1, 3'b010, 3'b101, 1'b1, 3'b010, 4'h9, 4'h3, 4'hC, 1'b0, 8'd5});
      vq.push_back('{4'h5, 1'b1, 3'b010, 3'b101, 1'b0, 3'b010, 4'h9, 4'h3, 4'hC, 1'b0, 8'd5});
      vq.push_back('{4'h6, 1'b1, 3'b001, 3'b101, 1'b1, 3'b011, 4'h6, 4'h3, 4'hC, 1'b0, 8'd5});
      vq.push_back('{4'h5, 1'b1, 3'b010, 3'b111, 1'b1, 3'b010, 4'h6, 4'h5, 4'hC, 1'b0, 8'd5});
      vq.push_back('{4'h0, 1'b0, 3'b000, 3'b111, 1'b1, 3'b000, 4'h6, 4'h5, 4'hC, 1'b0, 8'd5});
      vq.push_back('{4'h7, 1'b1, 3'b001, 3'b000, 1'b1, 3'b001, 4'h7, 4'h5, 4'hC, 1'b0, 8'd5});
      vq.push_back('{4'h2, 1'b1, 3'b100, 3'b000, 1'b1, 3'b101, 4'h7, 4'h5, 4'h2, 1'b0, 8'd5});

      rst      = 1'b1;
      in_data  = '0;
      in_valid = 1'b0;
      sel      = 3'b000;
      rdy      = 3'b111;
      #1;
      check("reset in_ready", in_ready, 0);
      check_outputs("reset", 3'b000, 4'h0, 4'h0, 4'h0, 1'b0, 8'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      foreach (vq[i]) begin
         @(negedge clk);
         in_data  = vq[i].d;
         in_valid = vq[i].v;
         sel      = vq[i].sel;
         rdy      = vq[i].rdy;
         #1;
         check($sformatf("v%0d in_ready", i), in_ready, vq[i].ir);
         @(posedge clk);
         #1;
         check_outputs($sformatf("v%0d", i), vq[i].ev, vq[i].e1, vq[i].e2, vq[i].e3,
                       vq[i].ese, vq[i].ecnt);
      end

      // Slots 1 and 3 are full and err_cnt is 5; reset must clear them without a clock edge.
      @(negedge clk);
      in_valid = 1'b0;
      sel      = 3'b000;
      #2;
      rst = 1'b1;
      #1;
      check("async rst in_ready", in_ready, 0);
      check_outputs("async rst", 3'b000, 4'h0, 4'h0, 4'h0, 1'b0, 8'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 260; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         sel      = 3'b000;
         in_data  = 4'(i);
         @(posedge clk);
         #1;
         if (i == 0)   check("sat first cnt", err_cnt, 1);
         if (i == 253) check("sat cnt 254", err_cnt, 254);
         if (i == 254) check("sat cnt 255", err_cnt, 255);
         if (i == 259) begin
            check("sat held cnt", err_cnt, 255);
            check("sat sel_err", sel_err, 1);
            check("sat no valid", {out3_valid, out2_valid, out1_valid}, 0);
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      check("idle sel_err", sel_err, 0);
      check("idle cnt", err_cnt, 255);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
